// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the iterative FFT core.
// Twiddles are built from an integer Taylor series so no real math is needed at elaboration.
package fft_pkg;

    localparam int BIT_INT  = 8;
    localparam int BIT_FRAC = 8;

    localparam int     TWW      = 32;
    localparam int     ANG_FRAC = 28;
    localparam longint PI_Q     = 64'sd843314857;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [TWW-1:0] re;
        logic signed [TWW-1:0] im;
    } cplx_t;

    function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
        logic [31:0] r;
        r = '0;
        for (int q = 0; q < bits; q++) begin
            r[q] = v[bits-1-q];
        end
        return r;
    endfunction

    // Forward twiddle e^(-j*2*pi*t/n) rounded to a 2^frac scale; angle kept in Q28.
    function automatic cplx_t twiddle(input int t, input int n, input int frac);
        longint th;
        longint th2;
        longint term;
        longint c;
        longint s;
        longint half;
        cplx_t  r;
        th   = (PI_Q * 64'sd2 * longint'(t)) / longint'(n);
        th2  = (th * th) >>> ANG_FRAC;
        c    = 64'sd1 <<< ANG_FRAC;
        term = c;
        for (int k = 1; k < 16; k++) begin
            term = -(((term * th2) >>> ANG_FRAC) / longint'((2 * k - 1) * (2 * k)));
            c    = c + term;
        end
        s    = th;
        term = th;
        for (int k = 1; k < 16; k++) begin
            term = -(((term * th2) >>> ANG_FRAC) / longint'((2 * k) * (2 * k + 1)));
            s    = s + term;
        end
        half = 64'sd1 <<< (ANG_FRAC - 1 - frac);
        r.re = TWW'((c + half) >>> (ANG_FRAC - frac));
        r.im = TWW'(-((s + half) >>> (ANG_FRAC - frac)));
        return r;
    endfunction

endpackage

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: x = a + b*w, y = a - b*w, product floored back to the sample scale.
// The twiddle arrives in forward form and is conjugated here for the inverse transform.
module fft_butterfly #(
    parameter int OW   = 19,
    parameter int TWW  = 32,
    parameter int FRAC = 8
) (
    input  logic signed [OW-1:0]  i_a_re,
    input  logic signed [OW-1:0]  i_a_im,
    input  logic signed [OW-1:0]  i_b_re,
    input  logic signed [OW-1:0]  i_b_im,
    input  logic signed [TWW-1:0] i_tw_re,
    input  logic signed [TWW-1:0] i_tw_im,
    input  logic                  i_inv,
    output logic signed [OW-1:0]  o_x_re,
    output logic signed [OW-1:0]  o_x_im,
    output logic signed [OW-1:0]  o_y_re,
    output logic signed [OW-1:0]  o_y_im
);

    localparam int PW = OW + TWW + 2;

    logic signed [PW-1:0] w_br;
    logic signed [PW-1:0] w_bi;
    logic signed [PW-1:0] w_wr;
    logic signed [PW-1:0] w_wi;
    logic signed [PW-1:0] w_pr_full;
    logic signed [PW-1:0] w_pi_full;
    logic signed [OW-1:0] w_pr;
    logic signed [OW-1:0] w_pi;

    always_comb begin
        w_br      = PW'(i_b_re);
        w_bi      = PW'(i_b_im);
        w_wr      = PW'(i_tw_re);
        w_wi      = i_inv ? -PW'(i_tw_im) : PW'(i_tw_im);
        w_pr_full = (w_br * w_wr) - (w_bi * w_wi);
        w_pi_full = (w_br * w_wi) + (w_bi * w_wr);
        w_pr      = OW'(w_pr_full >>> FRAC);
        w_pi      = OW'(w_pi_full >>> FRAC);
        o_x_re    = i_a_re + w_pr;
        o_x_im    = i_a_im + w_pi;
        o_y_re    = i_a_re - w_pr;
        o_y_im    = i_a_im - w_pi;
    end

endmodule

// File: rtl/iterative_fft.sv
// Iterative radix-2 DIT FFT/IFFT: one shared butterfly walks LOGN stages over an in-place
// register array. Samples load at bit-reversed addresses, bins unload in natural order.
module iterative_fft
    import fft_pkg::*;
#(
    parameter int  N    = 4,
    parameter int  W    = BIT_INT + BIT_FRAC,
    parameter int  FRAC = BIT_FRAC,
    localparam int LOGN = $clog2(N),
    localparam int OW   = W + 1 + LOGN
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inv,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W:0]    in_re,
    input  logic signed [W:0]    in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_re,
    output logic signed [OW-1:0] out_im,
    output logic [LOGN-1:0]      out_idx,
    output logic                 out_last,
    output logic                 busy
);
    // state  | meaning
    // S_LOAD | accepting samples, each written at its bit-reversed address
    // S_CALC | one in-place butterfly per cycle, stage by stage
    // S_OUT  | presenting bin k = 0..N-1, advancing on out_ready

    localparam int BW = (LOGN > 1) ? LOGN - 1 : 1;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;

    state_t               r_state;
    logic [LOGN-1:0]      r_n;
    logic [LOGN-1:0]      r_k;
    logic [SW-1:0]        r_stage;
    logic [BW-1:0]        r_bfly;
    logic                 r_mode;
    logic signed [OW-1:0] r_mem_re [N];
    logic signed [OW-1:0] r_mem_im [N];

    cplx_t                w_rom [N/2];
    cplx_t                w_tw;
    logic                 w_accept;
    logic [LOGN-1:0]      w_load_addr;
    logic [LOGN-1:0]      w_b_ext;
    logic [LOGN-1:0]      w_span;
    logic [LOGN-1:0]      w_pos;
    logic [LOGN-1:0]      w_grp;
    logic [LOGN-1:0]      w_idx_i;
    logic [LOGN-1:0]      w_idx_j;
    logic [BW-1:0]        w_tw_idx;
    logic signed [OW-1:0] w_x_re;
    logic signed [OW-1:0] w_x_im;
    logic signed [OW-1:0] w_y_re;
    logic signed [OW-1:0] w_y_im;

    for (genvar g = 0; g < N/2; g++) begin : g_rom
        localparam cplx_t TW = twiddle(g, N, FRAC);
        assign w_rom[g] = TW;
    end

    assign w_accept    = (r_state == S_LOAD) && in_valid;
    assign w_load_addr = LOGN'(bitrev(32'(r_n), LOGN));

    // Butterfly b of stage s pairs i and i+span inside group b>>s.
    always_comb begin
        w_b_ext  = LOGN'(r_bfly);
        w_span   = LOGN'(1) << r_stage;
        w_pos    = w_b_ext & (w_span - LOGN'(1));
        w_grp    = w_b_ext >> r_stage;
        w_idx_i  = ((w_grp << r_stage) << 1) | w_pos;
        w_idx_j  = w_idx_i | w_span;
        w_tw_idx = BW'(w_pos << (LOGN - 1 - int'(r_stage)));
    end

    assign w_tw = w_rom[w_tw_idx];

    fft_butterfly #(
        .OW   (OW),
        .TWW  (TWW),
        .FRAC (FRAC)
    ) u_bfly (
        .i_a_re  (r_mem_re[w_idx_i]),
        .i_a_im  (r_mem_im[w_idx_i]),
        .i_b_re  (r_mem_re[w_idx_j]),
        .i_b_im  (r_mem_im[w_idx_j]),
        .i_tw_re (w_tw.re),
        .i_tw_im (w_tw.im),
        .i_inv   (r_mode),
        .o_x_re  (w_x_re),
        .o_x_im  (w_x_im),
        .o_y_re  (w_y_re),
        .o_y_im  (w_y_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_LOAD;
            r_n     <= '0;
            r_k     <= '0;
            r_stage <= '0;
            r_bfly  <= '0;
            r_mode  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_n == '0) begin
                            r_mode <= inv;
                        end
                        if (r_n == LOGN'(N - 1)) begin
                            r_n     <= '0;
                            r_state <= S_CALC;
                        end else begin
                            r_n <= r_n + LOGN'(1);
                        end
                    end
                end
                S_CALC: begin
                    if (r_bfly == BW'(N/2 - 1)) begin
                        r_bfly <= '0;
                        if (r_stage == SW'(LOGN - 1)) begin
                            r_stage <= '0;
                            r_state <= S_OUT;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                        end
                    end else begin
                        r_bfly <= r_bfly + BW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (r_k == LOGN'(N - 1)) begin
                            r_k     <= '0;
                            r_state <= S_LOAD;
                        end else begin
                            r_k <= r_k + LOGN'(1);
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    // Sample store has no reset; every frame overwrites all N entries before use.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem_re[w_load_addr] <= OW'(in_re);
            r_mem_im[w_load_addr] <= OW'(in_im);
        end else if (r_state == S_CALC) begin
            r_mem_re[w_idx_i] <= w_x_re;
            r_mem_im[w_idx_i] <= w_x_im;
            r_mem_re[w_idx_j] <= w_y_re;
            r_mem_im[w_idx_j] <= w_y_im;
        end
    end

    assign in_ready  = (r_state == S_LOAD);
    assign out_valid = (r_state == S_OUT);
    assign busy      = (r_state != S_LOAD);
    assign out_idx   = r_k;
    assign out_last  = out_valid && (r_k == LOGN'(N - 1));
    assign out_re    = out_valid ? r_mem_re[r_k] : '0;
    assign out_im    = out_valid ? r_mem_im[r_k] : '0;

endmodule

// File: tb/tb_iterative_fft.sv
// Directed bench for iterative_fft: N=4 and N=8 instances, hand-computed Q8.8 spectra.
module tb_iterative_fft;

    logic               clk = 1'b0;
    logic               rst;
    logic               inv;
    logic signed [16:0] in_re;
    logic signed [16:0] in_im;
    logic               v4, v8, rdy4, rdy8;

    logic               ir4, ov4, ol4, busy4;
    logic signed [18:0] ore4, oim4;
    logic [1:0]         oidx4;
    logic               ir8, ov8, ol8, busy8;
    logic signed [19:0] ore8, oim8;
    logic [2:0]         oidx8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    iterative_fft #(.N(4), .W(16), .FRAC(8)) dut4 (
        .clk(clk), .rst(rst), .inv(inv), .in_valid(v4), .in_ready(ir4),
        .in_re(in_re), .in_im(in_im), .out_valid(ov4), .out_ready(rdy4),
        .out_re(ore4), .out_im(oim4), .out_idx(oidx4), .out_last(ol4), .busy(busy4)
    );

    iterative_fft #(.N(8), .W(16), .FRAC(8)) dut8 (
        .clk(clk), .rst(rst), .inv(inv), .in_valid(v8), .in_ready(ir8),
        .in_re(in_re), .in_im(in_im), .out_valid(ov8), .out_ready(rdy8),
        .out_re(ore8), .out_im(oim8), .out_idx(oidx8), .out_last(ol8), .busy(busy8)
    );

    // Present nb samples; inv is held at inv_first for sample 0 and inv_rest afterwards.
    task automatic load(input int nb, input int re[8], input int im[8], input bit gaps,
                        input bit inv_first, input bit inv_rest);
        for (int n = 0; n < nb; n++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    v4 = 1'b0;
                    v8 = 1'b0;
                    inv = inv_rest;
                    @(negedge clk);
                end
            end
            inv   = (n == 0) ? inv_first : inv_rest;
            in_re = 17'(re[n]);
            in_im = 17'(im[n]);
            if (nb == 4) v4 = 1'b1; else v8 = 1'b1;
            @(negedge clk);
        end
        v4 = 1'b0;
        v8 = 1'b0;
    endtask

    // Drain nb bins; unreached slots keep sentinel values so a stuck core shows up as bad bins.
    task automatic unload(input int nb, input bit stall, output int g_re[8], output int g_im[8],
                          output int g_idx[8], output int g_last[8], output int hold_bad);
        int k, guard, cre, cim, cidx, clast, p_re, p_im, p_idx;
        bit cv, rd, p_stalled;
        k = 0; guard = 0; hold_bad = 0; p_stalled = 1'b0; p_re = 0; p_im = 0; p_idx = 0;
        for (int q = 0; q < 8; q++) begin
            g_re[q] = -99999; g_im[q] = -99999; g_idx[q] = -1; g_last[q] = -1;
        end
        while (k < nb && guard < 3000) begin
            rd = stall ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (nb == 4) begin
                rdy4 = rd; cv = ov4; cre = ore4; cim = oim4; cidx = oidx4; clast = ol4;
            end else begin
                rdy8 = rd; cv = ov8; cre = ore8; cim = oim8; cidx = oidx8; clast = ol8;
            end
            if (p_stalled && (cre != p_re || cim != p_im || cidx != p_idx)) hold_bad++;
            p_stalled = cv && !rd;
            p_re = cre; p_im = cim; p_idx = cidx;
            if (cv && rd) begin
                g_re[k] = cre; g_im[k] = cim; g_idx[k] = cidx; g_last[k] = clast;
                k++;
            end
            @(negedge clk);
            guard++;
        end
        rdy4 = 1'b0;
        rdy8 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; inv = 1'b0; v4 = 1'b0; v8 = 1'b0; rdy4 = 1'b0; rdy8 = 1'b0;
        in_re = '0; in_im = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ir4 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready4: got %0d need 1", ir4); end
        n_cmp++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid4: got %0d need 0", ov4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy4: got %0d need 0", busy4); end
        n_cmp++; if (ol4 !== 1'b0) begin n_err++; $display("FAIL reset_out_last4: got %0d need 0", ol4); end
        n_cmp++; if (oidx4 !== 2'd0) begin n_err++; $display("FAIL reset_out_idx4: got %0d need 0", oidx4); end
        n_cmp++; if (ore4 !== 19'sd0) begin n_err++; $display("FAIL reset_out_re4: got %0d need 0", ore4); end
        n_cmp++; if (ir8 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready8: got %0d need 1", ir8); end
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL reset_out_valid8: got %0d need 0", ov8); end
        n_cmp++; if (oim8 !== 20'sd0) begin n_err++; $display("FAIL reset_out_im8: got %0d need 0", oim8); end
    endtask

    task automatic test_fwd4();
        int x_re[8] = '{256, 0, -256, 0, 0, 0, 0, 0};
        int x_im[8] = '{0, -256, 0, 256, 0, 0, 0, 0};
        int e_re[4] = '{0, 0, 0, 1024};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb;
        load(4, x_re, x_im, 1'b0, 1'b0, 1'b0);
        unload(4, 1'b0, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (g_re[k] !== e_re[k] || g_im[k] !== 0) begin
                n_err++;
                $display("FAIL fwd4_bin%0d: got (%0d,%0d) need (%0d,0)", k, g_re[k], g_im[k], e_re[k]);
            end
            n_cmp++;
            if (g_idx[k] !== k || g_last[k] !== int'(k == 3)) begin
                n_err++;
                $display("FAIL fwd4_idx%0d: got idx %0d last %0d need idx %0d last %0d",
                         k, g_idx[k], g_last[k], k, int'(k == 3));
            end
        end
    endtask

    // Back-to-back with the forward frame; inv drops after sample 0 and must not matter.
    task automatic test_inv4();
        int x_re[8] = '{256, 0, -256, 0, 0, 0, 0, 0};
        int x_im[8] = '{0, -256, 0, 256, 0, 0, 0, 0};
        int e_re[4] = '{0, 1024, 0, 0};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb;
        load(4, x_re, x_im, 1'b0, 1'b1, 1'b0);
        unload(4, 1'b0, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (g_re[k] !== e_re[k] || g_im[k] !== 0) begin
                n_err++;
                $display("FAIL inv4_bin%0d: got (%0d,%0d) need (%0d,0)", k, g_re[k], g_im[k], e_re[k]);
            end
        end
    endtask

    task automatic test_impulse8();
        int x_re[8] = '{256, 0, 0, 0, 0, 0, 0, 0};
        int x_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb, cyc;
        load(8, x_re, x_im, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL imp8_busy_calc: got %0d need 1", busy8); end
        n_cmp++; if (ir8 !== 1'b0) begin n_err++; $display("FAIL imp8_ready_calc: got %0d need 0", ir8); end
        cyc = 0;
        while (ov8 !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++; if (cyc !== 12) begin n_err++; $display("FAIL imp8_calc_cycles: got %0d need 12", cyc); end
        unload(8, 1'b0, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (g_re[k] !== 256 || g_im[k] !== 0) begin
                n_err++;
                $display("FAIL imp8_bin%0d: got (%0d,%0d) need (256,0)", k, g_re[k], g_im[k]);
            end
            n_cmp++;
            if (g_idx[k] !== k || g_last[k] !== int'(k == 7)) begin
                n_err++;
                $display("FAIL imp8_idx%0d: got idx %0d last %0d need idx %0d last %0d",
                         k, g_idx[k], g_last[k], k, int'(k == 7));
            end
        end
    endtask

    task automatic test_const8();
        int x_re[8] = '{256, 256, 256, 256, 256, 256, 256, 256};
        int x_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb;
        load(8, x_re, x_im, 1'b0, 1'b0, 1'b0);
        unload(8, 1'b0, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (g_re[k] !== ((k == 0) ? 2048 : 0) || g_im[k] !== 0) begin
                n_err++;
                $display("FAIL const8_bin%0d: got (%0d,%0d) need (%0d,0)", k, g_re[k], g_im[k],
                         (k == 0) ? 2048 : 0);
            end
        end
    endtask

    // Delayed impulse x[1]=1.0 gives X[k]=W8^k, exercising every twiddle under stalls and gaps.
    task automatic test_backpressure8();
        int x_re[8] = '{0, 256, 0, 0, 0, 0, 0, 0};
        int x_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int e_re[8] = '{256, 181, 0, -181, -256, -181, 0, 181};
        int e_im[8] = '{0, -181, -256, -181, 0, 181, 256, 181};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb;
        load(8, x_re, x_im, 1'b1, 1'b0, 1'b1);
        unload(8, 1'b1, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (g_re[k] !== e_re[k] || g_im[k] !== e_im[k]) begin
                n_err++;
                $display("FAIL bp8_bin%0d: got (%0d,%0d) need (%0d,%0d)", k, g_re[k], g_im[k],
                         e_re[k], e_im[k]);
            end
            n_cmp++;
            if (g_idx[k] !== k) begin
                n_err++;
                $display("FAIL bp8_idx%0d: got %0d need %0d", k, g_idx[k], k);
            end
        end
        n_cmp++; if (hb !== 0) begin n_err++; $display("FAIL bp8_hold_stable: got %0d changes need 0", hb); end
    endtask

    task automatic test_rst_mid_calc8();
        int x_re[8] = '{0, 0, 0, 256, 0, 0, 0, 0};
        int y_re[8] = '{256, 0, 0, 0, 0, 0, 0, 0};
        int x_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int g_re[8], g_im[8], g_idx[8], g_last[8], hb;
        load(8, x_re, x_im, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("FAIL rst8_busy_before: got %0d need 1", busy8); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (ir8 !== 1'b1) begin n_err++; $display("FAIL rst8_in_ready: got %0d need 1", ir8); end
        n_cmp++; if (ov8 !== 1'b0) begin n_err++; $display("FAIL rst8_out_valid: got %0d need 0", ov8); end
        n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("FAIL rst8_busy: got %0d need 0", busy8); end
        load(8, y_re, x_im, 1'b0, 1'b0, 1'b0);
        unload(8, 1'b0, g_re, g_im, g_idx, g_last, hb);
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (g_re[k] !== 256 || g_im[k] !== 0) begin
                n_err++;
                $display("FAIL rst8_bin%0d: got (%0d,%0d) need (256,0)", k, g_re[k], g_im[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fwd4();
        test_inv4();
        test_impulse8();
        test_const8();
        test_backpressure8();
        test_rst_mid_calc8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
